// File: rtl/serializador_bits_pkg.sv
// Shared types and defaults for the parallel-to-serial stage that feeds the
// three-ones sequence detector.
package pacote_serializador;

    typedef enum logic [0:0] {
        OCIOSO,
        DESLOCANDO
    } estado_ser_t;

    localparam int LARGURA_PADRAO = 8;

endpackage

// File: rtl/serializador_bits_buffer.sv
// One-entry holding register that parks the next word while the current
// word is still being shifted out.
module buffer_palavra #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_carregar,
    input  logic               i_drenar,
    input  logic [LARGURA-1:0] i_palavra,
    output logic [LARGURA-1:0] o_palavra,
    output logic               o_cheio
);

    logic [LARGURA-1:0] r_palavra;
    logic               r_cheio;

    // Load and drain never coincide: a load needs the buffer empty, a drain needs it full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_palavra <= '0;
            r_cheio   <= 1'b0;
        end else if (i_drenar) begin
            r_cheio   <= 1'b0;
        end else if (i_carregar) begin
            r_palavra <= i_palavra;
            r_cheio   <= 1'b1;
        end
    end

    assign o_palavra = r_palavra;
    assign o_cheio   = r_cheio;

endmodule

// File: rtl/serializador_bits.sv
// Serializes LARGURA-bit words one bit per cycle over a valid/ready handshake;
// the holding buffer lets consecutive words stream with no gap cycle.
module serializador_bits
    import pacote_serializador::*;
#(
    parameter int LARGURA   = LARGURA_PADRAO,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LARGURA-1:0] palavra_in,
    input  logic               palavra_valid,
    output logic               palavra_ready,
    output logic               bit_out,
    output logic               bit_valid,
    input  logic               bit_ready,
    output logic               ocupado
);

    localparam int            CW        = $clog2(LARGURA + 1);
    localparam logic [CW-1:0] CNT_CHEIO = CW'(LARGURA);

    estado_ser_t        r_estado;
    estado_ser_t        w_estadoProx;
    logic [LARGURA-1:0] r_sh;
    logic [LARGURA-1:0] w_shProx;
    logic [LARGURA-1:0] w_shDeslocado;
    logic [LARGURA-1:0] w_bufPalavra;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cntProx;
    logic               w_bufCheio;
    logic               w_aceita;
    logic               w_transf;
    logic               w_ultimo;
    logic               w_carregaBuf;
    logic               w_drenaBuf;
    logic               w_emDesloc;
    logic               w_bitSaida;

    buffer_palavra #(
        .LARGURA (LARGURA)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .i_carregar (w_carregaBuf),
        .i_drenar   (w_drenaBuf),
        .i_palavra  (palavra_in),
        .o_palavra  (w_bufPalavra),
        .o_cheio    (w_bufCheio)
    );

    // The output end is the MSB or LSB; the vacated end is zero-filled.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shDeslocado = {r_sh[LARGURA-2:0], 1'b0};
            assign w_bitSaida    = r_sh[LARGURA-1];
        end else begin : g_lsb
            assign w_shDeslocado = {1'b0, r_sh[LARGURA-1:1]};
            assign w_bitSaida    = r_sh[0];
        end
    endgenerate

    assign w_emDesloc    = reset && (r_estado == DESLOCANDO);
    assign palavra_ready = reset && !w_bufCheio;
    assign bit_valid     = w_emDesloc;
    assign bit_out       = w_emDesloc && w_bitSaida;
    assign ocupado       = reset && ((r_estado == DESLOCANDO) || w_bufCheio);

    assign w_aceita = palavra_valid && palavra_ready;
    assign w_transf = bit_valid && bit_ready;
    assign w_ultimo = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado <= OCIOSO;
            r_sh     <= '0;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_estadoProx;
            r_sh     <= w_shProx;
            r_cnt    <= w_cntProx;
        end
    end

    // At the last bit a parked word wins over a word arriving the same cycle.
    always_comb begin
        w_estadoProx = r_estado;
        w_shProx     = r_sh;
        w_cntProx    = r_cnt;
        w_carregaBuf = 1'b0;
        w_drenaBuf   = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (w_aceita) begin
                    w_shProx     = palavra_in;
                    w_cntProx    = CNT_CHEIO;
                    w_estadoProx = DESLOCANDO;
                end
            end
            DESLOCANDO: begin
                if (w_transf && w_ultimo) begin
                    if (w_bufCheio) begin
                        w_shProx   = w_bufPalavra;
                        w_cntProx  = CNT_CHEIO;
                        w_drenaBuf = 1'b1;
                    end else if (w_aceita) begin
                        w_shProx  = palavra_in;
                        w_cntProx = CNT_CHEIO;
                    end else begin
                        w_cntProx    = '0;
                        w_estadoProx = OCIOSO;
                    end
                end else begin
                    if (w_transf) begin
                        w_shProx  = w_shDeslocado;
                        w_cntProx = r_cnt - CW'(1);
                    end
                    w_carregaBuf = w_aceita;
                end
            end
            default: begin
                w_estadoProx = OCIOSO;
            end
        endcase
    end

endmodule

// File: tb/tb_serializador_bits.sv
// Scoreboard bench for serializador_bits: stimulus queues the expected serial
// bits, monitors pop and compare them on every bit transfer.
module tb_serializador_bits;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] palavraIn;
    logic       palavraValid;
    logic       palavraReady;
    logic       bitOut;
    logic       bitValid;
    logic       bitReady;
    logic       ocupado;

    logic [7:0] palavraIn2;
    logic       palavraValid2;
    logic       palavraReady2;
    logic       bitOut2;
    logic       bitValid2;
    logic       bitReady2 = 1'b1;
    logic       ocupado2;

    int   errors = 0;
    int   checks = 0;
    logic q[$];
    logic q2[$];

    always #5 clk = ~clk;

    serializador_bits #(.LARGURA(8), .MSB_FIRST(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .palavra_in    (palavraIn),
        .palavra_valid (palavraValid),
        .palavra_ready (palavraReady),
        .bit_out       (bitOut),
        .bit_valid     (bitValid),
        .bit_ready     (bitReady),
        .ocupado       (ocupado)
    );

    serializador_bits #(.LARGURA(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk           (clk),
        .reset         (reset),
        .palavra_in    (palavraIn2),
        .palavra_valid (palavraValid2),
        .palavra_ready (palavraReady2),
        .bit_out       (bitOut2),
        .bit_valid     (bitValid2),
        .bit_ready     (bitReady2),
        .ocupado       (ocupado2)
    );

    task automatic checkOutput(input string nome, input logic [15:0] atual, input logic [15:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offers a word; once ready is seen the hand-computed bit sequence is queued.
    task automatic applyStimulus(input logic [7:0] palavra, input logic [7:0] sequencia);
        bit aceito = 1'b0;
        palavraIn    = palavra;
        palavraValid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (palavraReady) begin
                aceito = 1'b1;
                break;
            end
        end
        if (!aceito) begin
            checks++;
            errors++;
            $display("[TB] FAIL aceitePalavra: word %0h never accepted, required ready=1", palavra);
        end else begin
            for (int b = 7; b >= 0; b--) q.push_back(sequencia[b]);
        end
        sync();
        palavraValid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && bitValid && bitReady) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL bitInesperado: got bit %0b with valid=1, required no bit at %0t", bitOut, $time);
            end else begin
                checkOutput("bitSerial", bitOut, q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset && bitValid2 && bitReady2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL bitInesperadoLsb: got bit %0b with valid=1, required no bit at %0t", bitOut2, $time);
            end else begin
                checkOutput("bitSerialLsb", bitOut2, q2.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        palavraIn     = 8'hAA;
        palavraValid  = 1'b1;
        palavraIn2    = 8'h55;
        palavraValid2 = 1'b1;
        bitReady      = 1'b1;

        // Reset held with valid high: nothing may be accepted or emitted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("readyReset", palavraReady, 0);
            checkOutput("validReset", bitValid, 0);
            checkOutput("ocupadoReset", ocupado, 0);
            checkOutput("readyResetLsb", palavraReady2, 0);
        end
        sync();
        reset         = 1'b1;
        palavraValid  = 1'b0;
        palavraValid2 = 1'b0;
        @(negedge clk);
        checkOutput("readyPosReset", palavraReady, 1);
        checkOutput("validPosReset", bitValid, 0);
        checkOutput("ocupadoPosReset", ocupado, 0);

        // Single word, MSB first
        sync();
        applyStimulus(8'hE0, 8'b1110_0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("validPalavra", bitValid, 1);
            checkOutput("ocupadoPalavra", ocupado, 1);
        end
        @(negedge clk);
        checkOutput("validFimPalavra", bitValid, 0);
        checkOutput("ocupadoFimPalavra", ocupado, 0);

        // Back-to-back words, second one parked in the buffer
        sync();
        applyStimulus(8'hA5, 8'b1010_0101);
        applyStimulus(8'h3C, 8'b0011_1100);
        palavraIn    = 8'hFF;
        palavraValid = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            checkOutput("validContinuo", bitValid, 1);
            checkOutput("readyBufCheio", palavraReady, (i <= 8) ? 16'd0 : 16'd1);
            if (i == 8) palavraValid = 1'b0;
        end
        @(negedge clk);
        checkOutput("validFimContinuo", bitValid, 0);

        // Stall for three cycles while the third bit is presented
        sync();
        applyStimulus(8'hF0, 8'b1111_0000);
        sync();
        sync();
        bitReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bitParado", bitOut, 1);
            checkOutput("validParado", bitValid, 1);
            sync();
        end
        bitReady = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("validAposParada", bitValid, 1);
        end
        @(negedge clk);
        checkOutput("validFimParada", bitValid, 0);

        // Reset after four bits of FF with 0F buffered: both words discarded
        sync();
        applyStimulus(8'hFF, 8'b1111_1111);
        applyStimulus(8'h0F, 8'b0000_1111);
        repeat (3) sync();
        checkOutput("ocupadoAntesReset", ocupado, 1);
        reset = 1'b0;
        q.delete();
        sync();
        @(negedge clk);
        checkOutput("validResetMeio", bitValid, 0);
        checkOutput("ocupadoResetMeio", ocupado, 0);
        sync();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("readyAposResetMeio", palavraReady, 1);
        repeat (12) begin
            @(negedge clk);
            checkOutput("ocupadoDescartado", ocupado, 0);
        end

        // LSB-first instance
        sync();
        begin
            bit aceito2 = 1'b0;
            palavraIn2    = 8'h07;
            palavraValid2 = 1'b1;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (palavraReady2) begin
                    aceito2 = 1'b1;
                    break;
                end
            end
            if (!aceito2) begin
                checks++;
                errors++;
                $display("[TB] FAIL aceiteLsb: word 07 never accepted, required ready=1");
            end else begin
                logic [7:0] seqLsb;
                seqLsb = 8'b1110_0000;
                for (int b = 7; b >= 0; b--) q2.push_back(seqLsb[b]);
            end
            sync();
            palavraValid2 = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("validLsb", bitValid2, 1);
        end
        @(negedge clk);
        checkOutput("validFimLsb", bitValid2, 0);

        repeat (2) @(negedge clk);
        checkOutput("filaVazia", 16'(q.size()), 0);
        checkOutput("filaVaziaLsb", 16'(q2.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
